// File: rtl/ultrasonic_scheduler.sv
// Purpose : shares one ultrasonic ranging sensor between two requesters (fault check, pickup check).
// Latency : grant/trigger one cycle after a request is seen in IDLE; done one cycle after echo fall or timeout.
// Backpr. : requests are level-held and only sampled in IDLE; anything raised during a measurement or GAP waits.
//
// Ports:
//   clk_50M     in   system clock (single clock domain)
//   rst_n       in   synchronous active-low reset
//   req[1:0]    in   level request per requester (bit0 fault check, bit1 pickup check)
//   UV_echo     in   asynchronous echo from the sensor
//   UV_trig     out  trigger pulse to the sensor, TRIG_CYCLES wide
//   grant[1:0]  out  one-hot owner of the running measurement, 0 when idle or in GAP
//   done[1:0]   out  one-cycle result-valid pulse on the owner's bit
//   echo_width  out  echo-high width in cycles, held until the next done
//   timeout     out  result ended without a complete echo, held with echo_width
//   busy        out  high whenever the scheduler is not idle
module ultrasonic_scheduler #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_250_000,
  parameter int GAP_CYCLES     = 3_000_000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic        UV_echo,
  output logic        UV_trig,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [21:0] echo_width,
  output logic        timeout,
  output logic        busy
);

  // One phase counter is shared by TRIG and GAP, so it is sized for the longer of the two.
  localparam int PH_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] TRIG_LAST = PW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [21:0]   WIDTH_MAX = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t        state_q;
  logic [PW-1:0] phase_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [21:0]   width_q;

  // Echo synchronizer plus one history flop for edge detection.
  logic          echo_meta_q;
  logic          echo_sync_q;
  logic          echo_prev_q;
  logic          echo_s;

  // Round-robin memory: index of the requester served most recently.
  logic          last_q;

  logic          trig_q;
  logic [1:0]    grant_q;
  logic [1:0]    done_q;
  logic [21:0]   echo_width_q;
  logic          timeout_q;
  logic          busy_q;

  logic [1:0]    grant_sel_d;
  logic          echo_rise_d;
  logic [TW-1:0] tmo_next_d;
  logic          tmo_hit_d;
  logic [21:0]   width_inc_d;
  logic          meas_end_d;
  logic          end_tmo_d;
  logic [21:0]   end_width_d;

  assign echo_s = echo_sync_q;

  // Tie goes to whichever requester was not served last; a lone request always wins.
  always_comb begin
    grant_sel_d = 2'b00;
    if (req[0] && (!req[1] || last_q)) begin
      grant_sel_d = 2'b01;
    end else if (req[1]) begin
      grant_sel_d = 2'b10;
    end
  end

  // An echo already high when WAIT_RISE is entered has echo_prev_q high too, so it never counts.
  assign echo_rise_d = echo_s & ~echo_prev_q;
  assign tmo_next_d  = tmo_cnt_q + TW'(1);
  assign tmo_hit_d   = (tmo_next_d == TMO_LIMIT);
  assign width_inc_d = (width_q == WIDTH_MAX) ? width_q : (width_q + 22'd1);

  // Measurement end decision. Timeout has priority over echo fall; when both land on the same
  // cycle the width already accumulated is reported together with timeout=1.
  always_comb begin
    meas_end_d  = 1'b0;
    end_tmo_d   = 1'b0;
    end_width_d = width_q;
    case (state_q)
      WAIT_RISE: begin
        if (tmo_hit_d) begin
          meas_end_d  = 1'b1;
          end_tmo_d   = 1'b1;
          end_width_d = width_q;
        end
      end
      MEASURE: begin
        if (tmo_hit_d) begin
          meas_end_d  = 1'b1;
          end_tmo_d   = 1'b1;
          end_width_d = echo_s ? width_inc_d : width_q;
        end else if (!echo_s) begin
          meas_end_d  = 1'b1;
          end_tmo_d   = 1'b0;
          end_width_d = width_q;
        end
      end
      default: begin
        meas_end_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      width_q      <= '0;
      echo_meta_q  <= 1'b0;
      echo_sync_q  <= 1'b0;
      echo_prev_q  <= 1'b0;
      last_q       <= 1'b1;
      trig_q       <= 1'b0;
      grant_q      <= 2'b00;
      done_q       <= 2'b00;
      echo_width_q <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      echo_meta_q <= UV_echo;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_sync_q;
      done_q      <= 2'b00;

      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q     <= grant_sel_d;
            last_q      <= grant_sel_d[1];
            trig_q      <= 1'b1;
            busy_q      <= 1'b1;
            phase_cnt_q <= '0;
            state_q     <= TRIG;
          end
        end

        TRIG: begin
          if (phase_cnt_q == TRIG_LAST) begin
            trig_q    <= 1'b0;
            tmo_cnt_q <= '0;
            width_q   <= '0;
            state_q   <= WAIT_RISE;
          end else begin
            phase_cnt_q <= phase_cnt_q + PW'(1);
          end
        end

        WAIT_RISE, MEASURE: begin
          tmo_cnt_q <= tmo_next_d;
          if (meas_end_d) begin
            echo_width_q <= end_width_d;
            timeout_q    <= end_tmo_d;
            done_q       <= grant_q;
            grant_q      <= 2'b00;
            phase_cnt_q  <= '0;
            state_q      <= GAP;
          end else if (state_q == WAIT_RISE) begin
            if (echo_rise_d) begin
              // The rising cycle itself is the first high cycle of the echo.
              width_q <= 22'd1;
              state_q <= MEASURE;
            end
          end else begin
            width_q <= width_inc_d;
          end
        end

        GAP: begin
          if (phase_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            phase_cnt_q <= phase_cnt_q + PW'(1);
          end
        end

        default: begin
          trig_q  <= 1'b0;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign UV_trig    = trig_q;
  assign grant      = grant_q;
  assign done       = done_q;
  assign echo_width = echo_width_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

  // Structural invariants of the scheduler.
  a_trig_in_trig: assert property (@(posedge clk_50M) disable iff (!rst_n)
    trig_q |-> (state_q == TRIG));
  a_grant_onehot: assert property (@(posedge clk_50M) disable iff (!rst_n)
    $onehot0(grant_q));
  a_done_onehot: assert property (@(posedge clk_50M) disable iff (!rst_n)
    $onehot0(done_q));
  a_busy_state: assert property (@(posedge clk_50M) disable iff (!rst_n)
    busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Purpose : self-checking bench for ultrasonic_scheduler with an outcome-level reference model.
// Latency : every expected event time is predicted from the stimulus, never awaited from the DUT.
// Backpr. : requests are held or dropped per transaction; GAP waiting is checked through busy/trigger.
module tb_ultrasonic_scheduler;

  localparam int T_TRIG = 5;
  localparam int T_TMO  = 100;
  localparam int T_GAP  = 20;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic        UV_echo;
  logic        UV_trig;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [21:0] echo_width;
  logic        timeout;
  logic        busy;

  int n_cmp   = 0;
  int n_err   = 0;
  int rr_last = 1;   // model: index served last; reset favours requester 0
  int txn_id  = 0;

  ultrasonic_scheduler #(
    .TRIG_CYCLES   (T_TRIG),
    .TIMEOUT_CYCLES(T_TMO),
    .GAP_CYCLES    (T_GAP)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .req       (req),
    .UV_echo   (UV_echo),
    .UV_trig   (UV_trig),
    .grant     (grant),
    .done      (done),
    .echo_width(echo_width),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL t%0d %s: got 0x%0h expected 0x%0h", txn_id, tag, got, exp);
    end
  endtask

  // One measurement, started from an idle scheduler in the current cycle.
  // The echo pulse is described in drive cycles relative to the first cycle after the trigger
  // (k=0): UV_echo high for k in [r, r+w). The model reasons about what the sensor window sees:
  // the synchronized echo lags the pin by 2 cycles, the window spans T_TMO cycles after the
  // trigger, and the final window cycle is the timeout decision.
  task automatic run_txn(input logic [1:0] r_req, input bit hold, input bit stuck,
                         input bit has_rise, input int r, input int w);
    int         gi;
    int         k0;
    int         k1;
    int         kend;
    int         exp_w;
    bit         exp_t;
    int         done_c;
    logic [1:0] g;
    txn_id++;

    if (r_req == 2'b11) gi = (rr_last == 0) ? 1 : 0;
    else                gi = r_req[1] ? 1 : 0;
    rr_last = gi;
    g = (gi == 1) ? 2'b10 : 2'b01;

    if (stuck || !has_rise) begin
      kend  = T_TMO - 1;
      exp_w = 0;
      exp_t = 1'b1;
    end else begin
      k0 = r + 2;
      k1 = k0 + w;
      if (k1 >= T_TMO - 1) begin
        kend  = T_TMO - 1;
        exp_t = 1'b1;
        exp_w = ((k1 > T_TMO) ? T_TMO : k1) - k0;
      end else begin
        kend  = k1;
        exp_t = 1'b0;
        exp_w = w;
      end
    end
    done_c = kend + 1;

    req     = r_req;
    UV_echo = stuck;
    for (int i = 1; i <= T_TRIG; i++) begin
      tick();
      if (i == 1 && !hold) req = 2'b00;
      chk("trig_high", UV_trig, 1'b1);
      chk("grant_trig", grant, g);
      chk("busy_trig", busy, 1'b1);
    end

    for (int k = 0; k <= done_c + T_GAP; k++) begin
      tick();
      UV_echo = stuck ? (k < done_c) : (has_rise && k >= r && k < r + w);
      chk("trig_low", UV_trig, 1'b0);
      if (k == done_c) begin
        chk("done", done, g);
        chk("echo_width", echo_width, exp_w);
        chk("timeout", timeout, exp_t);
        chk("grant_gap", grant, 2'b00);
      end else begin
        chk("done_idle", done, 2'b00);
      end
      if (k < done_c) chk("grant_meas", grant, g);
      chk("busy", busy, (k < done_c + T_GAP));
      if (k == done_c + T_GAP) begin
        chk("width_held", echo_width, exp_w);
        chk("timeout_held", timeout, exp_t);
      end
    end
  endtask

  // Reset in the third trigger cycle: trigger drops at that edge, every output clears, no done follows.
  task automatic reset_mid_trig();
    txn_id++;
    UV_echo = 1'b0;
    req     = 2'b01;
    tick();
    chk("rst_trig_started", UV_trig, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    chk("rst_trig", UV_trig, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_width", echo_width, 22'd0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n   = 1'b1;
    rr_last = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_done", done, 2'b00);
      chk("post_rst_trig", UV_trig, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end
  endtask

  initial begin
    logic [1:0] rq;
    rst_n   = 1'b0;
    req     = 2'b00;
    UV_echo = 1'b0;
    repeat (3) tick();
    chk("reset_trig", UV_trig, 1'b0);
    chk("reset_grant", grant, 2'b00);
    chk("reset_done", done, 2'b00);
    chk("reset_width", echo_width, 22'd0);
    chk("reset_timeout", timeout, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Held tie: grants alternate starting with requester 0.
    run_txn(2'b11, 1'b1, 1'b0, 1'b1, 10, 40);
    run_txn(2'b11, 1'b1, 1'b0, 1'b1, 20, 25);
    run_txn(2'b11, 1'b1, 1'b0, 1'b1, 0, 1);
    // Basic measurement, no echo, echo stuck high, request dropped after grant.
    run_txn(2'b01, 1'b0, 1'b0, 1'b1, 10, 40);
    run_txn(2'b10, 1'b0, 1'b0, 1'b0, 0, 0);
    run_txn(2'b01, 1'b0, 1'b1, 1'b0, 0, 0);
    run_txn(2'b01, 1'b0, 1'b0, 1'b1, 5, 30);
    // Echo fall one cycle before, exactly on, and after the timeout decision.
    run_txn(2'b01, 1'b0, 1'b0, 1'b1, 50, 46);
    run_txn(2'b10, 1'b0, 1'b0, 1'b1, 50, 47);
    run_txn(2'b01, 1'b0, 1'b0, 1'b1, 30, 200);
    // Reset during trigger, then a tie must again favour requester 0.
    reset_mid_trig();
    run_txn(2'b11, 1'b0, 1'b0, 1'b1, 10, 40);

    for (int n = 0; n < 10; n++) begin
      rq = 2'($urandom_range(1, 3));
      run_txn(rq, bit'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 7) != 0),
              int'($urandom_range(0, 60)), int'($urandom_range(1, 70)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ultrasonic_scheduler.md
ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

Interface
REQ-001 Parameter TRIG_CYCLES, default 500, trigger pulse width in clk_50M cycles (10 us).
REQ-002 Parameter TIMEOUT_CYCLES, default 1_250_000, max cycles from trigger end to echo fall (25 ms).
REQ-003 Parameter GAP_CYCLES, default 3_000_000, mandatory quiet time after each measurement (60 ms).
REQ-004 clk_50M  input  1  system clock, 50 MHz; the block has one clock.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 req  input  2  per-requester level request for one ranging measurement (bit0 fault check, bit1 pickup check).
REQ-007 UV_echo  input  1  asynchronous echo from the ultrasonic sensor.
REQ-008 UV_trig  output  1  trigger to the sensor.
REQ-009 grant  output  2  one-hot owner of the current measurement, 0 when idle.
REQ-010 done  output  2  one-cycle pulse to the owner when its result is valid.
REQ-011 echo_width  output  22  measured echo-high width in cycles, held until the next done.
REQ-012 timeout  output  1  set with done when no complete echo occurred, held with echo_width.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 UV_echo SHALL pass through a 2-flop synchronizer; all echo logic SHALL use the synchronized signal (echo_s).
REQ-015 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
REQ-016 IDLE: req sampled only here; on any req bit set, grant SHALL load next cycle and the FSM SHALL enter TRIG.
REQ-017 Arbitration SHALL be round-robin: with both bits set, the requester not served last wins; after reset req[0] wins the first tie.
REQ-018 TRIG: UV_trig SHALL be high for exactly TRIG_CYCLES cycles, then low on entry to WAIT_RISE.
REQ-019 WAIT_RISE: a 0->1 edge of echo_s SHALL move to MEASURE; echo_s already high on entry SHALL NOT count as an edge.
REQ-020 MEASURE: width counter SHALL increment each cycle echo_s is high; echo_s low SHALL end the measurement.
REQ-021 One timeout counter SHALL run from WAIT_RISE entry through MEASURE; reaching TIMEOUT_CYCLES SHALL end the measurement with timeout=1.
REQ-022 On measurement end: echo_width SHALL take the counter value (0 if no rising edge), done SHALL pulse on the grant bit for one cycle, FSM SHALL enter GAP.
REQ-023 Width counter SHALL saturate at all-ones and never wrap.
REQ-024 GAP: grant SHALL drop to 0 and UV_trig SHALL stay low for GAP_CYCLES cycles, then IDLE; requests during GAP SHALL wait.
REQ-025 Deasserting req mid-measurement SHALL NOT abort; the measurement completes and done still pulses.
REQ-026 Echo end and timeout in the same cycle SHALL report timeout=1 with the saturated/current width.
REQ-027 UV_trig SHALL never be high outside TRIG.

Reset
REQ-028 rst_n low at a clock edge SHALL force IDLE, UV_trig=0, grant=0, done=0, echo_width=0, timeout=0, busy=0, all counters and the synchronizer cleared, round-robin pointer to favor req[0].
REQ-029 Reset mid-TRIG or mid-MEASURE SHALL drop UV_trig at that edge and produce no done pulse.

Verification (bench parameters TRIG_CYCLES=5, TIMEOUT_CYCLES=100, GAP_CYCLES=20)
REQ-030 req=01, echo high 40 cycles 10 cycles after trigger -> UV_trig high 5 cycles, done=01, echo_width=40, timeout=0, busy low 20 cycles after done.
REQ-031 req=11 held -> grants alternate 01,10,01; each done matches its grant, with at least 20 idle-trigger cycles between triggers.
REQ-032 req=10, echo never rises -> done=10 at 100 cycles after trigger end, echo_width=0, timeout=1.
REQ-033 Echo stuck high before and through trigger -> no rising edge, timeout=1, echo_width=0.
REQ-034 rst_n low on cycle 3 of TRIG -> UV_trig=0 next edge, no done; a fresh req=01 after release runs a full measurement.
REQ-035 req=01 dropped after grant, echo 30 cycles -> done=01 still pulses, echo_width=30.
